issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Parametrised in-order multi-lane issue controller for the superscalar core, sitting between the decoders and the execution lanes. It holds a register scoreboard that tracks destinations issued but not yet written back, and decides each cycle which in-order prefix of the decoded bundle may issue. It generalises dual issue to LANES lanes and NREGS registers. It adds multi-cycle writeback, a configurable memory-port structural limit, branch bundle termination and stall accounting.

## Interface
- LANES, 2: issue lanes per bundle; lane 0 is oldest.
- NREGS, 32: architectural registers; register 0 is hard-wired zero.
- MEM_PORTS, 1: maximum memory ops issued per cycle.
- RW, $clog2(NREGS): register index width (derived).

- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  branch or redirect; suppresses all issue this cycle.
- dec_valid  in  LANES  lane holds a decoded instruction.
- dec_rs1, dec_rs2, dec_rd  in  LANES*RW each  source and destination indices; lane i occupies bits [i*RW +: RW].
- dec_use_rs1, dec_use_rs2  in  LANES each  source operand is read.
- dec_reg_write  in  LANES  lane writes dec_rd.
- dec_is_mem, dec_is_branch  in  LANES each  lane class.
- wb_valid  in  LANES  writeback port fires.
- wb_rd  in  LANES*RW  writeback register index.
- issue  out  LANES  lane issues this cycle; always an in-order prefix.
- bundle_done  out  1  every valid lane issued; upstream may advance.
- stall  out  1  some valid lane held back and flush is low.
- busy_regs  out  NREGS  scoreboard state (registered).
- stall_cycles  out  32  saturating count of stall cycles.
- sb_err  out  1  sticky; a writeback targeted a non-busy register.

## Operation
- busy(r) = scoreboard[r] and r≠0. Under ISSUE_BYPASS_EN, busy(r) is also false when any wb lane clears r this cycle.
- Lane i issues only if all of the following hold:
  - dec_valid[i] is set, and every lane j<i issues.
  - flush=0.
  - No used source of lane i is busy.
  - If dec_reg_write[i], dec_rd[i] is not busy (WAW stall).
  - No older lane j<i with dec_reg_write and rd≠0 has rd equal to a used source of lane i or to lane i's rd.
  - The count of dec_is_mem over lanes 0..i is ≤ MEM_PORTS.
  - No lane j<i is a branch. A branch may issue, but it ends the bundle's issue for that cycle.
- Unissued valid lanes stay presented by upstream until issued. bundle_done = all dec_valid lanes issued; this is also 1 when no lane is valid.
- Scoreboard next state = (scoreboard & ~clear) | set.
  - clear comes from wb_valid lanes.
  - set comes from issued lanes with reg_write and rd≠0.
  - If the same register is cleared and set in one cycle, set wins.
- Register 0 is never set.
- Writeback to a non-busy register (including r0): the clear is ignored and sb_err is set until reset.
- flush does not clear the scoreboard. Issued instructions always write back.
- stall_cycles increments on each stall cycle and saturates at 0xFFFF_FFFF.

## Timing
- issue, stall and bundle_done are combinational from dec_*, flush, wb_* and the registered scoreboard. There is no added latency.
- Scoreboard, stall_cycles and sb_err update on posedge clk.
- Without bypass, a writeback in cycle t releases its dependants in cycle t+1. With bypass, it releases them in cycle t.
- Reset (asynchronous, at any time, including mid-bundle): busy_regs=0, stall_cycles=0, sb_err=0. While reset is high, issue=0, stall=0 and bundle_done=0.
- With LANES=1, the intra-bundle checks are vacuous.

## Configuration
- ISSUE_BYPASS_EN defined: same-cycle writeback clears count as ready for the sources and WAW checks of the current bundle.
- ISSUE_BYPASS_EN undefined: readiness uses only the registered scoreboard, for a one-cycle writeback-to-issue bubble. The scoreboard update rule is identical in both builds.

## Structure
- core_types_pkg holds:
  - an issue_req_t struct per lane: valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, is_mem, is_branch.
  - an ISSUE_STALL_SAT constant.
- One sub-module, issue_lane_check, instantiated once per lane. It computes lane-local readiness from the scoreboard view and the older lanes' destinations. The top level contains the prefix chain, the memory-count limit, the scoreboard and the counters.

## Test plan
- After reset, bundle {add x5,x1,x2 ; add x6,x3,x4} -> issue=2'b11, bundle_done=1, and busy_regs bits 5 and 6 set the next cycle.
- Lane0 writes x5 and lane1 reads x5 -> issue=2'b01, stall=1, stall_cycles=1. The next cycle, lane1 still stalls on busy x5 until wb_rd=5. It issues in the cycle after the writeback, or in the same cycle under ISSUE_BYPASS_EN.
- Two loads with MEM_PORTS=1 -> issue=2'b01. Loads in both lanes with MEM_PORTS=2 -> issue=2'b11.
- Branch in lane0, ALU op in lane1 -> issue=2'b01. With flush=1 and the same bundle -> issue=2'b00, stall=0, scoreboard unchanged.
- wb_valid with wb_rd=7 while x7 is not busy -> sb_err=1 and it stays high. The same cycle with issue setting x9 and wb clearing x9 -> x9 remains busy.
- Reset asserted while x3 is busy and 10 stalls have been counted -> busy_regs=0, stall_cycles=0, issue=0 immediately without waiting for a clock.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared types for the issue stage: per-lane decoded request and stall counter limit.
package core_types_pkg;

  localparam int unsigned ISSUE_RW_MAX  = 8;
  localparam int unsigned ISSUE_CNT_W   = 32;
  localparam logic [ISSUE_CNT_W-1:0] ISSUE_STALL_SAT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic                    valid;
    logic [ISSUE_RW_MAX-1:0] rs1;
    logic [ISSUE_RW_MAX-1:0] rs2;
    logic                    use_rs1;
    logic                    use_rs2;
    logic [ISSUE_RW_MAX-1:0] rd;
    logic                    reg_write;
    logic                    is_mem;
    logic                    is_branch;
  } issue_req_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/issue bundle between the decoders and the issue scoreboard.
interface issue_scoreboard_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned RW = $clog2(NREGS);

  logic                flush;
  logic [LANES-1:0]    dec_valid;
  logic [LANES*RW-1:0] dec_rs1;
  logic [LANES*RW-1:0] dec_rs2;
  logic [LANES*RW-1:0] dec_rd;
  logic [LANES-1:0]    dec_use_rs1;
  logic [LANES-1:0]    dec_use_rs2;
  logic [LANES-1:0]    dec_reg_write;
  logic [LANES-1:0]    dec_is_mem;
  logic [LANES-1:0]    dec_is_branch;
  logic [LANES-1:0]    wb_valid;
  logic [LANES*RW-1:0] wb_rd;
  logic [LANES-1:0]    issue;
  logic                bundle_done;
  logic                stall;

  modport master (
    output flush, dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
           dec_reg_write, dec_is_mem, dec_is_branch, wb_valid, wb_rd,
    input  issue, bundle_done, stall
  );

  modport slave (
    input  flush, dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
           dec_reg_write, dec_is_mem, dec_is_branch, wb_valid, wb_rd,
    output issue, bundle_done, stall
  );

endinterface

// File: rtl/issue_lane_check.sv
// Lane-local readiness: scoreboard RAW/WAW hazards plus hazards against older lanes' destinations.
module issue_lane_check
  import core_types_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned NREGS = 32
) (
  input  issue_req_t                          req,
  input  logic [NREGS-1:0]                    busy_view,
  input  logic [LANES-1:0]                    older_wr,
  input  logic [LANES-1:0][ISSUE_RW_MAX-1:0]  older_rd,
  output logic                                ready_c,
  output logic                                mem_c,
  output logic                                branch_c
);

  localparam int unsigned EXT_W = 1 << ISSUE_RW_MAX;

  logic [EXT_W-1:0] busy_ext;
  logic             hazard;

  assign busy_ext = EXT_W'(busy_view);

  always_comb begin
    hazard = 1'b0;
    if (req.use_rs1 && busy_ext[req.rs1])   hazard = 1'b1;
    if (req.use_rs2 && busy_ext[req.rs2])   hazard = 1'b1;
    if (req.reg_write && busy_ext[req.rd])  hazard = 1'b1;
    // older_wr only carries lanes ahead of this one that write a nonzero rd
    for (int j = 0; j < int'(LANES); j++) begin
      if (older_wr[j] &&
          ((req.use_rs1 && older_rd[j] == req.rs1) ||
           (req.use_rs2 && older_rd[j] == req.rs2) ||
           (older_rd[j] == req.rd)))
        hazard = 1'b1;
    end
  end

  assign ready_c  = req.valid && !hazard;
  assign mem_c    = req.valid && req.is_mem;
  assign branch_c = req.valid && req.is_branch;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-lane issue controller with register scoreboard and stall accounting.
// Optional build macro ISSUE_BYPASS_EN: same-cycle writebacks count as ready for the current bundle.
module issue_scoreboard
  import core_types_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned MEM_PORTS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  issue_scoreboard_if.slave      bus,
  output logic [NREGS-1:0]       busy_regs,
  output logic [ISSUE_CNT_W-1:0] stall_cycles,
  output logic                   sb_err
);

  localparam int unsigned RW = $clog2(NREGS);

  issue_req_t [LANES-1:0]                       reqs;
  logic [LANES-1:0]                             older_wr [LANES];
  logic [LANES-1:0][ISSUE_RW_MAX-1:0]           older_rd [LANES];
  logic [LANES-1:0]                             lane_ready;
  logic [LANES-1:0]                             lane_mem;
  logic [LANES-1:0]                             lane_branch;
  logic [LANES-1:0]                             issue_c;
  logic                                         stall_c;
  logic [NREGS-1:0]                             sb_q, sb_d, clear, set, busy_view;
  logic                                         wb_err;

  // Unpack the flat decode buses into per-lane requests
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      reqs[i].valid     = bus.dec_valid[i];
      reqs[i].rs1       = ISSUE_RW_MAX'(bus.dec_rs1[i*RW +: RW]);
      reqs[i].rs2       = ISSUE_RW_MAX'(bus.dec_rs2[i*RW +: RW]);
      reqs[i].use_rs1   = bus.dec_use_rs1[i];
      reqs[i].use_rs2   = bus.dec_use_rs2[i];
      reqs[i].rd        = ISSUE_RW_MAX'(bus.dec_rd[i*RW +: RW]);
      reqs[i].reg_write = bus.dec_reg_write[i];
      reqs[i].is_mem    = bus.dec_is_mem[i];
      reqs[i].is_branch = bus.dec_is_branch[i];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      older_wr[i] = '0;
      older_rd[i] = '0;
      for (int j = 0; j < i; j++) begin
        older_wr[i][j] = reqs[j].reg_write && (reqs[j].rd != '0);
        older_rd[i][j] = reqs[j].rd;
      end
    end
  end

  // Writeback clears; a writeback to a non-busy register is dropped and flagged
  always_comb begin
    logic [RW-1:0] idx;
    clear  = '0;
    wb_err = 1'b0;
    idx    = '0;
    for (int w = 0; w < int'(LANES); w++) begin
      if (bus.wb_valid[w]) begin
        idx = bus.wb_rd[w*RW +: RW];
        if (idx != '0 && sb_q[idx]) clear[idx] = 1'b1;
        else                        wb_err     = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef ISSUE_BYPASS_EN
    busy_view = sb_q & ~clear;
`else
    busy_view = sb_q;
`endif
    busy_view[0] = 1'b0;
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    issue_lane_check #(
      .LANES (LANES),
      .NREGS (NREGS)
    ) u_chk (
      .req       (reqs[g]),
      .busy_view (busy_view),
      .older_wr  (older_wr[g]),
      .older_rd  (older_rd[g]),
      .ready_c   (lane_ready[g]),
      .mem_c     (lane_mem[g]),
      .branch_c  (lane_branch[g])
    );
  end

  // In-order prefix: memory-port limit and branch termination
  always_comb begin
    logic        chain;
    logic        older_br;
    int unsigned mem_cnt;
    issue_c  = '0;
    chain    = !reset && !bus.flush;
    older_br = 1'b0;
    mem_cnt  = 0;
    for (int i = 0; i < int'(LANES); i++) begin
      mem_cnt = mem_cnt + 32'(lane_mem[i]);
      if (chain && lane_ready[i] && (mem_cnt <= MEM_PORTS) && !older_br)
        issue_c[i] = 1'b1;
      else
        chain = 1'b0;
      older_br = older_br | lane_branch[i];
    end
  end

  assign stall_c         = !reset && !bus.flush && (|(bus.dec_valid & ~issue_c));
  assign bus.issue       = issue_c;
  assign bus.stall       = stall_c;
  assign bus.bundle_done = !reset && ((bus.dec_valid & ~issue_c) == '0);

  // Set wins over clear; r0 never becomes busy
  always_comb begin
    set = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (issue_c[i] && bus.dec_reg_write[i] && bus.dec_rd[i*RW +: RW] != '0)
        set[bus.dec_rd[i*RW +: RW]] = 1'b1;
    end
    sb_d    = (sb_q & ~clear) | set;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q         <= '0;
      stall_cycles <= '0;
      sb_err       <= 1'b0;
    end else begin
      sb_q <= sb_d;
      if (stall_c && stall_cycles != ISSUE_STALL_SAT)
        stall_cycles <= stall_cycles + ISSUE_CNT_W'(1);
      if (wb_err)
        sb_err <= 1'b1;
    end
  end

  assign busy_regs = sb_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; a second instance with MEM_PORTS=2 mirrors the stimulus.
module tb_issue_scoreboard;

  localparam int unsigned LANES = 2;
  localparam int unsigned NREGS = 32;
  localparam int unsigned RW    = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] busy_regs, busy_regs_m2;
  logic [31:0] stall_cycles, stall_cycles_m2;
  logic        sb_err, sb_err_m2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stalls = 0;

  issue_scoreboard_if #(.LANES(LANES), .NREGS(NREGS)) sb_if ();
  issue_scoreboard_if #(.LANES(LANES), .NREGS(NREGS)) m2_if ();

  assign m2_if.flush         = sb_if.flush;
  assign m2_if.dec_valid     = sb_if.dec_valid;
  assign m2_if.dec_rs1       = sb_if.dec_rs1;
  assign m2_if.dec_rs2       = sb_if.dec_rs2;
  assign m2_if.dec_rd        = sb_if.dec_rd;
  assign m2_if.dec_use_rs1   = sb_if.dec_use_rs1;
  assign m2_if.dec_use_rs2   = sb_if.dec_use_rs2;
  assign m2_if.dec_reg_write = sb_if.dec_reg_write;
  assign m2_if.dec_is_mem    = sb_if.dec_is_mem;
  assign m2_if.dec_is_branch = sb_if.dec_is_branch;
  assign m2_if.wb_valid      = sb_if.wb_valid;
  assign m2_if.wb_rd         = sb_if.wb_rd;

  issue_scoreboard #(.LANES(LANES), .NREGS(NREGS), .MEM_PORTS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (sb_if),
    .busy_regs    (busy_regs),
    .stall_cycles (stall_cycles),
    .sb_err       (sb_err)
  );

  issue_scoreboard #(.LANES(LANES), .NREGS(NREGS), .MEM_PORTS(2)) dut_m2 (
    .clk          (clk),
    .reset        (reset),
    .bus          (m2_if),
    .busy_regs    (busy_regs_m2),
    .stall_cycles (stall_cycles_m2),
    .sb_err       (sb_err_m2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    sb_if.flush         = 1'b0;
    sb_if.dec_valid     = '0;
    sb_if.dec_rs1       = '0;
    sb_if.dec_rs2       = '0;
    sb_if.dec_rd        = '0;
    sb_if.dec_use_rs1   = '0;
    sb_if.dec_use_rs2   = '0;
    sb_if.dec_reg_write = '0;
    sb_if.dec_is_mem    = '0;
    sb_if.dec_is_branch = '0;
    sb_if.wb_valid      = '0;
    sb_if.wb_rd         = '0;
  endtask

  task automatic lane(input int i, input int rs1, input int rs2, input int rd,
                      input bit u1, input bit u2, input bit wr, input bit mem, input bit br);
    sb_if.dec_valid[i]          = 1'b1;
    sb_if.dec_rs1[i*RW +: RW]   = RW'(rs1);
    sb_if.dec_rs2[i*RW +: RW]   = RW'(rs2);
    sb_if.dec_rd[i*RW +: RW]    = RW'(rd);
    sb_if.dec_use_rs1[i]        = u1;
    sb_if.dec_use_rs2[i]        = u2;
    sb_if.dec_reg_write[i]      = wr;
    sb_if.dec_is_mem[i]         = mem;
    sb_if.dec_is_branch[i]      = br;
  endtask

  task automatic wb(input int w, input int rd);
    sb_if.wb_valid[w]        = 1'b1;
    sb_if.wb_rd[w*RW +: RW]  = RW'(rd);
  endtask

  task automatic comb_chk(input string tag, input logic [1:0] e_issue, input bit e_done, input bit e_stall);
    #1;
    check({tag, "_issue"}, 32'(sb_if.issue), 32'(e_issue));
    check({tag, "_done"},  32'(sb_if.bundle_done), 32'(e_done));
    check({tag, "_stall"}, 32'(sb_if.stall), 32'(e_stall));
    if (e_stall) exp_stalls++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    lane(0, 1, 2, 5, 1, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue", 32'(sb_if.issue), 32'h0);
    check("rst_done",  32'(sb_if.bundle_done), 32'h0);
    check("rst_stall", 32'(sb_if.stall), 32'h0);
    check("rst_busy",  busy_regs, 32'h0);
    check("rst_cnt",   stall_cycles, 32'h0);
    check("rst_err",   32'(sb_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // add x5,x1,x2 ; add x6,x3,x4
    lane(0, 1, 2, 5, 1, 1, 1, 0, 0);
    lane(1, 3, 4, 6, 1, 1, 1, 0, 0);
    comb_chk("dual", 2'b11, 1'b1, 1'b0);
    tick();
    check("dual_busy", busy_regs, 32'h0000_0060);

    next(); wb(0, 5); wb(1, 6);
    comb_chk("wb56", 2'b00, 1'b1, 1'b0);
    tick();
    check("wb56_busy", busy_regs, 32'h0);
    check("wb56_err", 32'(sb_err), 32'h0);

    // intra-bundle RAW on x5
    next();
    lane(0, 1, 2, 5, 1, 1, 1, 0, 0);
    lane(1, 5, 3, 8, 1, 1, 1, 0, 0);
    comb_chk("raw", 2'b01, 1'b0, 1'b1);
    tick();
    check("raw_busy", busy_regs, 32'h0000_0020);
    check("raw_cnt", stall_cycles, 32'd1);

    next(); lane(0, 5, 3, 8, 1, 1, 1, 0, 0);
    comb_chk("rawsb", 2'b00, 1'b0, 1'b1);
    tick();
    check("rawsb_cnt", stall_cycles, 32'd2);

    next(); lane(0, 5, 3, 8, 1, 1, 1, 0, 0); wb(0, 5);
`ifdef ISSUE_BYPASS_EN
    comb_chk("wbrel", 2'b01, 1'b1, 1'b0);
    tick();
    check("wbrel_busy", busy_regs, 32'h0000_0100);
`else
    comb_chk("wbrel", 2'b00, 1'b0, 1'b1);
    tick();
    check("wbrel_busy", busy_regs, 32'h0);
    next(); lane(0, 5, 3, 8, 1, 1, 1, 0, 0);
    comb_chk("wbrel2", 2'b01, 1'b1, 1'b0);
    tick();
    check("wbrel2_busy", busy_regs, 32'h0000_0100);
`endif
    check("wbrel_cnt", stall_cycles, 32'(exp_stalls));

    next(); wb(0, 8);
    comb_chk("wb8", 2'b00, 1'b1, 1'b0);
    tick();
    check("wb8_busy", busy_regs, 32'h0);

    // two loads: one memory port vs two
    next();
    lane(0, 1, 0, 10, 1, 0, 1, 1, 0);
    lane(1, 2, 0, 11, 1, 0, 1, 1, 0);
    comb_chk("mem1", 2'b01, 1'b0, 1'b1);
    check("mem2_issue", 32'(m2_if.issue), 32'h3);
    tick();
    check("mem1_busy", busy_regs, 32'h0000_0400);
    check("mem1_cnt", stall_cycles, 32'(exp_stalls));

    next(); wb(0, 10);
    comb_chk("wb10", 2'b00, 1'b1, 1'b0);
    tick();

    // branch bundle, first flushed then presented
    next(); sb_if.flush = 1'b1;
    lane(0, 1, 2, 0, 1, 1, 0, 0, 1);
    lane(1, 3, 4, 12, 1, 1, 1, 0, 0);
    comb_chk("flush", 2'b00, 1'b0, 1'b0);
    tick();
    check("flush_busy", busy_regs, 32'h0);
    check("flush_cnt", stall_cycles, 32'(exp_stalls));

    next();
    lane(0, 1, 2, 0, 1, 1, 0, 0, 1);
    lane(1, 3, 4, 12, 1, 1, 1, 0, 0);
    comb_chk("branch", 2'b01, 1'b0, 1'b1);
    tick();
    check("branch_busy", busy_regs, 32'h0);

    // writeback to a non-busy register
    next(); wb(0, 7);
    comb_chk("badwb", 2'b00, 1'b1, 1'b0);
    tick();
    check("badwb_err", 32'(sb_err), 32'h1);
    next();
    tick();
    check("badwb_sticky", 32'(sb_err), 32'h1);

    // set of x9 with a dropped clear of x9 in the same cycle
    next(); lane(0, 1, 2, 9, 1, 1, 1, 0, 0); wb(1, 9);
    comb_chk("setclr", 2'b01, 1'b1, 1'b0);
    tick();
    check("setclr_busy", busy_regs, 32'h0000_0200);

    next(); lane(0, 1, 2, 9, 1, 1, 1, 0, 0); wb(0, 9);
`ifdef ISSUE_BYPASS_EN
    comb_chk("waw9", 2'b01, 1'b1, 1'b0);
    tick();
    check("waw9_busy", busy_regs, 32'h0000_0200);
`else
    comb_chk("waw9", 2'b00, 1'b0, 1'b1);
    tick();
    check("waw9_busy", busy_regs, 32'h0);
`endif

    next(); lane(0, 1, 2, 3, 1, 1, 1, 0, 0);
    comb_chk("x3", 2'b01, 1'b1, 1'b0);
    tick();
`ifdef ISSUE_BYPASS_EN
    check("x3_busy", busy_regs, 32'h0000_0208);
`else
    check("x3_busy", busy_regs, 32'h0000_0008);
`endif

    while (exp_stalls < 10) begin
      next(); lane(0, 3, 1, 4, 1, 1, 1, 0, 0);
      comb_chk("x3dep", 2'b00, 1'b0, 1'b1);
      tick();
    end
    check("pre_rst_cnt", stall_cycles, 32'd10);

    // asynchronous reset mid-cycle with the dependant still presented
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy",  busy_regs, 32'h0);
    check("arst_cnt",   stall_cycles, 32'h0);
    check("arst_issue", 32'(sb_if.issue), 32'h0);
    check("arst_stall", 32'(sb_if.stall), 32'h0);
    check("arst_done",  32'(sb_if.bundle_done), 32'h0);
    check("arst_err",   32'(sb_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    comb_chk("post_rst", 2'b01, 1'b1, 1'b0);
    tick();
    check("post_rst_busy", busy_regs, 32'h0000_0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
